// File: rtl/pll_lock_sequencer.sv
// PLL lock supervisor: reset sequencing, lock timeout/qualification,
// retry/fault tracking and per-channel PSDA phase stepping.
// Ports: clkin, reset (sync, active-high), pll_lock, pll_reset,
// pll_psda, ps_req/ps_dir/ps_ch/ps_ack, ready, fault, retry_cnt.
// Option: define PLL_LOCK_SYNC_EN to add 2-flop lock synchronisers.
module pll_lock_sequencer #(
  parameter int         NUM_PLL       = 1,
  parameter int         RST_CYCLES    = 16,
  parameter int         LOCK_TIMEOUT  = 65536,
  parameter int         STABLE_CYCLES = 1024,
  parameter int         SETTLE_CYCLES = 64,
  parameter int         MAX_RETRY     = 3,
  parameter logic [3:0] PSDA_INIT     = 4'b1100,
  localparam int        CH_W =
    (NUM_PLL > 1) ? $clog2(NUM_PLL) : 1
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic [NUM_PLL-1:0]   pll_lock,
  output logic [NUM_PLL-1:0]   pll_reset,
  output logic [4*NUM_PLL-1:0] pll_psda,
  input  logic                 ps_req,
  input  logic                 ps_dir,
  input  logic [CH_W-1:0]      ps_ch,
  output logic                 ps_ack,
  output logic                 ready,
  output logic                 fault,
  output logic [7:0]           retry_cnt
);

  localparam logic [31:0] RST_LAST =
    32'((RST_CYCLES > 1) ? RST_CYCLES - 1 : 0);
  localparam logic [31:0] TMO_LAST =
    32'((LOCK_TIMEOUT > 1) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [31:0] STB_LAST =
    32'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 1 : 0);
  localparam logic [31:0] STL_LAST =
    32'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_LOCK,
    STABLE,
    READY,
    PHASE_SETTLE,
    FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] fail_q, fail_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  retry_sat;
  logic        ack_q, ack_d;
  logic        armed_q, armed_d;
  logic        step_en;
  logic [31:0] ch_ext;
  logic        ch_valid;
  logic [NUM_PLL-1:0] lock_s;
  logic        all_lock;
  logic [3:0]  psda_q [NUM_PLL];

`ifdef PLL_LOCK_SYNC_EN
  logic [NUM_PLL-1:0] lock_m, lock_q;

  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_m <= '0;
      lock_q <= '0;
    end else begin
      lock_m <= pll_lock;
      lock_q <= lock_m;
    end
  end

  assign lock_s = lock_q;
`else
  assign lock_s = pll_lock;
`endif

  assign all_lock  = &lock_s;
  assign ch_ext    = 32'(ps_ch);
  assign ch_valid  = ch_ext < 32'(NUM_PLL);
  assign retry_sat = (retry_q == 8'hFF) ? retry_q
                                        : retry_q + 8'd1;

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= RESET_HOLD;
      cnt_q   <= '0;
      tmo_q   <= '0;
      fail_q  <= '0;
      retry_q <= '0;
      ack_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      fail_q  <= fail_d;
      retry_q <= retry_d;
      ack_q   <= ack_d;
      armed_q <= armed_d;
    end
  end

  // armed blocks a held ps_req from causing a second step:
  // it re-arms only after ps_req is seen low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    fail_d  = fail_q;
    retry_d = retry_q;
    ack_d   = 1'b0;
    step_en = 1'b0;
    armed_d = ps_req ? armed_q : 1'b1;
    unique case (state_q)
      RESET_HOLD: begin
        if (cnt_q >= RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_LOCK: begin
        if (all_lock) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (tmo_q >= TMO_LAST) begin
          retry_d = retry_sat;
          fail_d  = fail_q + 32'd1;
          cnt_d   = '0;
          if (fail_q + 32'd1 >= 32'(MAX_RETRY))
            state_d = FAULT;
          else
            state_d = RESET_HOLD;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      // a glitch here falls back without touching the timeout
      STABLE: begin
        if (!all_lock) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q >= STB_LAST) begin
          state_d = READY;
          fail_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      READY: begin
        if (!all_lock) begin
          state_d = RESET_HOLD;
          cnt_d   = '0;
          retry_d = retry_sat;
        end else if (ps_req && armed_q) begin
          armed_d = 1'b0;
          if (ch_valid) begin
            step_en = 1'b1;
            state_d = PHASE_SETTLE;
            cnt_d   = '0;
          end else begin
            ack_d = 1'b1;
          end
        end
      end
      PHASE_SETTLE: begin
        if (!all_lock) begin
          state_d = RESET_HOLD;
          cnt_d   = '0;
          retry_d = retry_sat;
        end else if (cnt_q >= STL_LAST) begin
          state_d = READY;
          ack_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RESET_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // phase words survive re-lock; only reset restores them
  always_ff @(posedge clkin) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLL; i++)
        psda_q[i] <= PSDA_INIT;
    end else if (step_en) begin
      for (int i = 0; i < NUM_PLL; i++)
        if (ch_ext == 32'(i))
          psda_q[i] <= ps_dir ? psda_q[i] + 4'd1
                              : psda_q[i] - 4'd1;
    end
  end

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_psda
    assign pll_psda[4*g +: 4] = psda_q[g];
  end

  assign pll_reset = {NUM_PLL{(state_q == RESET_HOLD) ||
                              (state_q == FAULT)}};
  assign ready     = (state_q == READY);
  assign fault     = (state_q == FAULT);
  assign ps_ack    = ack_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer (2- and 3-channel builds).
// Step vectors from a table; acks checked against a scoreboard queue.
module tb_pll_lock_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2, req2, dir2, ch2;
  logic [1:0] lock2, pllrst2;
  logic [7:0] psda2, retry2;
  logic       ack2, ready2, fault2;

  logic       rst3, req3, dir3;
  logic [1:0] ch3;
  logic [2:0] lock3, pllrst3;
  logic [11:0] psda3;
  logic [7:0] retry3;
  logic       ack3, ready3, fault3;

  pll_lock_sequencer #(
    .NUM_PLL(2), .RST_CYCLES(4), .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8), .SETTLE_CYCLES(4), .MAX_RETRY(3)
  ) u_d2 (
    .clkin(clk), .reset(rst2), .pll_lock(lock2),
    .pll_reset(pllrst2), .pll_psda(psda2),
    .ps_req(req2), .ps_dir(dir2), .ps_ch(ch2),
    .ps_ack(ack2), .ready(ready2), .fault(fault2),
    .retry_cnt(retry2)
  );

  pll_lock_sequencer #(
    .NUM_PLL(3), .RST_CYCLES(4), .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8), .SETTLE_CYCLES(4), .MAX_RETRY(3)
  ) u_d3 (
    .clkin(clk), .reset(rst3), .pll_lock(lock3),
    .pll_reset(pllrst3), .pll_psda(psda3),
    .ps_req(req3), .ps_dir(dir3), .ps_ch(ch3),
    .ps_ack(ack3), .ready(ready3), .fault(fault3),
    .retry_cnt(retry3)
  );

  typedef struct {
    logic       ch;
    logic       dir;
    logic [7:0] exp;
    int         hold;
  } vec_t;

  typedef struct {
    logic [11:0] psda;
    int          lat;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[7];
  int   n_run, n_fail;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic step2(input vec_t v, input string name);
    sb_t e, g;
    int  lowc;
    bit  got;
    e.psda = {4'h0, v.exp};
    e.lat  = 5;
    sb.push_back(e);
    req2 = 1'b1; ch2 = v.ch; dir2 = v.dir;
    lowc = 0; got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      tick();
      if (ack2) begin
        got = 1'b1;
        g = sb.pop_front();
        chk({name, " psda"}, 32'(psda2), 32'(g.psda));
        chk({name, " ack_lat"}, k, g.lat);
        chk({name, " ready_w_ack"}, 32'(ready2), 1);
        chk({name, " ready_low"}, lowc, 4);
      end else if (!ready2) begin
        lowc++;
      end
    end
    if (!got) begin
      void'(sb.pop_front());
      chk({name, " ack_seen"}, 0, 1);
    end
    for (int h = 0; h < v.hold; h++) begin
      tick();
      chk({name, " held_no_ack"}, 32'(ack2), 0);
    end
    if (v.hold > 0)
      chk({name, " held_psda"}, 32'(psda2), 32'(v.exp));
    req2 = 1'b0;
    tick();
    chk({name, " ack_pulse"}, 32'(ack2), 0);
  endtask

  initial begin
    int  cnt, lat, acks;
    sb_t e, g;
    bit  got;
    n_run = 0; n_fail = 0;
    rst2 = 1'b1; req2 = 1'b0; dir2 = 1'b0; ch2 = 1'b0;
    lock2 = 2'b00;
    rst3 = 1'b1; req3 = 1'b0; dir3 = 1'b0; ch3 = 2'd0;
    lock3 = 3'b000;

    tbl[0] = '{1'b1, 1'b1, 8'hDC, 0};
    tbl[1] = '{1'b0, 1'b1, 8'hDD, 0};
    tbl[2] = '{1'b0, 1'b1, 8'hDE, 0};
    tbl[3] = '{1'b0, 1'b1, 8'hDF, 0};
    tbl[4] = '{1'b0, 1'b1, 8'hD0, 0};
    tbl[5] = '{1'b0, 1'b0, 8'hDF, 0};
    tbl[6] = '{1'b0, 1'b1, 8'hD0, 5};

    repeat (3) tick();
    chk("rst pll_reset", 32'(pllrst2), 32'h3);
    chk("rst psda", 32'(psda2), 32'hCC);
    chk("rst ready", 32'(ready2), 0);
    chk("rst fault", 32'(fault2), 0);
    chk("rst ack", 32'(ack2), 0);
    chk("rst retry", 32'(retry2), 0);

    // reset-hold length after release
    rst2 = 1'b0;
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (pllrst2 == 2'b11) cnt++;
      else break;
    end
    chk("hold cycles", cnt, 4);
    chk("hold released", 32'(pllrst2), 0);

    repeat (5) tick();
    lock2 = 2'b11;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ready2) begin lat = k; break; end
    end
    chk("ready latency", lat, 9);
    chk("retry after lock", 32'(retry2), 0);

    for (int i = 0; i < 7; i++)
      step2(tbl[i], $sformatf("step%0d", i));

    // lock loss in READY
    lock2 = 2'b01;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (pllrst2 == 2'b11) cnt++;
      else if (cnt > 0) break;
    end
    chk("relock hold", cnt, 4);
    chk("relock retry", 32'(retry2), 1);
    chk("relock psda kept", 32'(psda2), 32'hD0);
    chk("relock ready", 32'(ready2), 0);

    // one-cycle glitch during STABLE
    lock2 = 2'b11;
    repeat (3) tick();
    lock2 = 2'b01;
    tick();
    lock2 = 2'b11;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ready2) begin lat = k; break; end
    end
    chk("glitch ready lat", lat, 9);
    chk("glitch retry", 32'(retry2), 1);

    // reset mid-operation
    rst2 = 1'b1;
    tick();
    chk("midrst psda", 32'(psda2), 32'hCC);
    chk("midrst ready", 32'(ready2), 0);
    chk("midrst retry", 32'(retry2), 0);
    tick();

    // repeated timeouts -> fault
    lock2 = 2'b01;
    rst2 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (fault2) begin lat = k; break; end
    end
    chk("fault time", lat, 108);
    chk("fault pll_reset", 32'(pllrst2), 32'h3);
    chk("fault retry", 32'(retry2), 3);
    chk("fault ready", 32'(ready2), 0);

    req2 = 1'b1; ch2 = 1'b0; dir2 = 1'b1;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ack2) acks++;
    end
    req2 = 1'b0;
    chk("fault no ack", acks, 0);
    chk("fault psda", 32'(psda2), 32'hCC);
    lock2 = 2'b11;
    repeat (20) tick();
    chk("fault sticky", 32'(fault2), 1);
    chk("fault no ready", 32'(ready2), 0);
    rst2 = 1'b1;
    tick();
    chk("fault cleared", 32'(fault2), 0);

    // 3-channel build: out-of-range channel
    rst3 = 1'b0;
    lock3 = 3'b111;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (ready3) begin got = 1'b1; break; end
    end
    chk("d3 ready", 32'(got), 1);

    e.psda = 12'hCCC; e.lat = 1;
    sb.push_back(e);
    req3 = 1'b1; ch3 = 2'd3; dir3 = 1'b1;
    got = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (ack3) begin
        got = 1'b1;
        g = sb.pop_front();
        chk("d3 bad ch psda", 32'(psda3), 32'(g.psda));
        chk("d3 bad ch lat", k, g.lat);
        chk("d3 bad ch ready", 32'(ready3), 1);
        break;
      end
    end
    if (!got) begin
      void'(sb.pop_front());
      chk("d3 bad ch ack", 0, 1);
    end
    req3 = 1'b0;
    tick();
    chk("d3 bad ch pulse", 32'(ack3), 0);

    e.psda = 12'hBCC; e.lat = 5;
    sb.push_back(e);
    req3 = 1'b1; ch3 = 2'd2; dir3 = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ack3) begin
        got = 1'b1;
        g = sb.pop_front();
        chk("d3 ch2 psda", 32'(psda3), 32'(g.psda));
        chk("d3 ch2 lat", k, g.lat);
        break;
      end
    end
    if (!got) begin
      void'(sb.pop_front());
      chk("d3 ch2 ack", 0, 1);
    end
    req3 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Parametrised supervisor for NUM_PLL Gowin rPLL instances, such as the DDR clock PLLs.
- Sequences PLL reset, waits for lock with a timeout, and qualifies lock as stable before asserting ready.
- Re-sequences automatically on lock loss and reports a fault after repeated failed attempts.
- Owns each PLL's dynamic phase word (PSDA) and steps it on request through a req/ack handshake with a settle delay. This is the hook used for DDR read-phase calibration.

Parameters:
- NUM_PLL, 1, number of supervised PLLs; range 1..8.
- RST_CYCLES, 16, cycles pll_reset is held high per attempt; must be ≥1.
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before an attempt fails.
- STABLE_CYCLES, 1024, consecutive all-locked cycles required before ready.
- SETTLE_CYCLES, 64, cycles waited after a phase step before ack.
- MAX_RETRY, 3, consecutive failed attempts that cause FAULT.
- PSDA_INIT, 4'b1100, reset phase word for every channel.
- Localparam CH_W = max(1, clog2(NUM_PLL)).

Ports:
- clkin  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pll_lock  in  NUM_PLL  LOCK outputs of the PLLs.
- pll_reset  out  NUM_PLL  RESET inputs of the PLLs; all bits are always equal.
- pll_psda  out  4*NUM_PLL  PSDA word per channel; channel i occupies bits [4i+3:4i].
- ps_req  in  1  phase-step request, level-held until ps_ack.
- ps_dir  in  1  step direction: 1 = +1, 0 = −1.
- ps_ch  in  CH_W  channel to step.
- ps_ack  out  1  one-cycle pulse: step done (or step ignored).
- ready  out  1  all PLLs locked and stable; no step in progress.
- fault  out  1  retry limit reached; sticky until reset.
- retry_cnt  out  8  total failed attempts; saturates at 255.

Behaviour:
- Reset values:
  - state = RESET_HOLD; pll_reset = all 1s.
  - Each pll_psda channel = PSDA_INIT.
  - ready, fault, ps_ack = 0; retry_cnt = 0; internal fail counter = 0.
- RESET_HOLD: pll_reset = 1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with pll_reset = 0.
- WAIT_LOCK: the timeout counter runs.
  - All lock bits = 1 → go to STABLE.
  - Timeout counter reaches LOCK_TIMEOUT → attempt failed.
- Attempt failed:
  - retry_cnt increments (saturating) and the fail counter increments.
  - Fail counter == MAX_RETRY → FAULT; otherwise → RESET_HOLD.
- STABLE: counts consecutive cycles with all lock bits = 1.
  - Any lock bit = 0 → return to WAIT_LOCK. The timeout counter is not reset and no retry is counted.
  - Count reaches STABLE_CYCLES → READY. ready = 1 from the next cycle, and the fail counter clears.
- READY: ready = 1.
  - Any lock bit = 0 → RESET_HOLD, ready = 0 the next cycle, and retry_cnt increments.
  - ps_req = 1 with ps_ch < NUM_PLL → PSDA[ps_ch] ← PSDA[ps_ch] ± 1, modulo 16 (15+1 = 0, 0−1 = 15). ready drops and state becomes PHASE_SETTLE.
  - ps_req = 1 with ps_ch ≥ NUM_PLL → no change; ps_ack pulses on the next cycle.
  - Lock loss takes priority over a simultaneous ps_req.
- PHASE_SETTLE: waits SETTLE_CYCLES.
  - Then ps_ack pulses for one cycle, state returns to READY, and ready = 1 in the same cycle as ps_ack.
  - Lock loss during settle → RESET_HOLD, no ack is issued, and the step is kept.
- ps_req must be sampled low for at least one cycle after ps_ack before a new step is accepted; no double-step on a held req.
- PSDA values persist across re-lock sequences and are restored only by reset.
- FAULT: pll_reset = 1, fault = 1, ready = 0, ps_req ignored. Exit only via reset.
- reset asserted mid-operation → all state returns to reset values on the next edge.

Optional Feature:
- Macro PLL_LOCK_SYNC_EN.
- Defined: each pll_lock bit passes through a 2-flop synchroniser on clkin before use, adding 2 cycles of lock-detect latency. Synchroniser flops reset to 0.
- Undefined: pll_lock is used directly; the caller guarantees it is synchronous to clkin.

Test Plan (NUM_PLL=2, RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, SETTLE_CYCLES=4, MAX_RETRY=3, macro undefined):
1. Release reset; drive pll_lock = 2'b11 from cycle 10 → pll_reset = 2'b11 for 4 cycles after reset, ready rises 8 cycles after lock is first sampled, retry_cnt = 0.
2. Drive lock = 2'b01 forever → timeout after 32 cycles in WAIT_LOCK, repeated 3 times, then fault = 1, pll_reset = 2'b11, retry_cnt = 3.
3. From READY, ps_req=1, ps_ch=1, ps_dir=1 → pll_psda[7:4] goes 1100→1101, ready low for 4 cycles, ps_ack single pulse, ready = 1 with ps_ack.
4. Set PSDA[0] = 15 via three +1 steps, then one more +1 step → wraps to 0. From 0, a −1 step → 15.
5. ps_req with ps_ch=... is infeasible at NUM_PLL=2 with CH_W=1; rerun with NUM_PLL=3 and ps_ch=3 → ps_ack the next cycle and all psda words unchanged.
6. Drop lock[1] for 1 cycle during STABLE → stable count restarts with no retry. Drop it in READY → pll_reset reasserted for 4 cycles, retry_cnt = 1, PSDA values retained.
